// File: rtl/frame_ctrl.sv
// frame_ctrl: per-frame beat gate between the DMA reader/writer and the pipeline stage.
// Latency: src -> pipe 1 cycle through a 2-entry skid; ret -> sink 0 cycles (gated pass-through).
// Backpressure: src_ready comes from registered occupancy and the feed count only; ret_ready follows sink_ready until out_len beats are delivered.
//
// Ports:
//   clk, rst_n                  single clock, asynchronous active-low reset
//   start, in_len, out_len      frame start pulse and beat counts, sampled in IDLE
//   src_valid/ready/data        beats from the DMA reader
//   pipe_valid/ready/data       beats into the pipeline (skid head)
//   ret_valid/ready/data        results out of the pipeline
//   sink_valid/ready/data       results to the DMA writer
//   busy, done                  frame running / one-cycle completion pulse
//   in_count, out_count         beats accepted / delivered in the current or last frame
//   timeout                     sticky watchdog flag
//
// Optional feature: define FRAME_CTRL_TIMEOUT_EN to build the stall watchdog.
// Without it no watchdog exists and timeout is constant 0.

module frame_ctrl #(
   parameter int DATA_W    = 64,
   parameter int LEN_W     = 32,
   parameter int TIMEOUT_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  in_len,
   input  logic [LEN_W-1:0]  out_len,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [DATA_W-1:0] src_data,
   output logic              pipe_valid,
   input  logic              pipe_ready,
   output logic [DATA_W-1:0] pipe_data,
   input  logic              ret_valid,
   output logic              ret_ready,
   input  logic [DATA_W-1:0] ret_data,
   output logic              sink_valid,
   input  logic              sink_ready,
   output logic [DATA_W-1:0] sink_data,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  in_count,
   output logic [LEN_W-1:0]  out_count,
   output logic              timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   logic [LEN_W-1:0]  in_len_q;
   logic [LEN_W-1:0]  out_len_q;

   // Two-entry skid: storage, pointers and registered occupancy.
   logic [DATA_W-1:0] skid_mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        occ;

   logic run;
   logic ret_gate;
   logic push;
   logic pop;
   logic sink_hs;
   logic complete;
   logic wd_expired;

   assign run = (state == RUN);

   // Feed side: depends only on registered state, so pipe_ready never
   // reaches src_ready combinationally.
   assign src_ready  = run && (in_count != in_len_q) && (occ != 2'd2);
   assign pipe_valid = (occ != 2'd0);
   assign pipe_data  = skid_mem[rd_ptr];

   // Return side: pass-through, closed once out_len beats have gone out so
   // surplus pipeline output waits rather than being dropped.
   assign ret_gate   = run && (out_count != out_len_q);
   assign sink_valid = ret_valid & ret_gate;
   assign ret_ready  = sink_ready & ret_gate;
   assign sink_data  = ret_data;

   assign push    = src_valid & src_ready;
   assign pop     = pipe_valid & pipe_ready;
   assign sink_hs = sink_valid & sink_ready;

   assign complete = (in_count == in_len_q) && (occ == 2'd0) &&
                     (out_count == out_len_q);

`ifdef FRAME_CTRL_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd_cnt;
   assign wd_expired = &wd_cnt;
`else
   assign wd_expired = 1'b0;
   // Watchdog width only matters when the watchdog is built; this keeps the
   // parameter referenced while the flag stays constant 0.
   assign timeout = (TIMEOUT_W < 0);
`endif

   // Skid storage carries no reset: occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         skid_mem[wr_ptr] <= src_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_len_q  <= '0;
         out_len_q <= '0;
         in_count  <= '0;
         out_count <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         occ       <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
         wd_cnt    <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  in_len_q  <= in_len;
                  out_len_q <= out_len;
                  in_count  <= '0;
                  out_count <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
`ifdef FRAME_CTRL_TIMEOUT_EN
                  wd_cnt    <= '0;
                  timeout   <= 1'b0;
`endif
               end
            end

            RUN: begin
               if (push) begin
                  in_count <= in_count + LEN_W'(1);
                  wr_ptr   <= ~wr_ptr;
               end
               if (pop) begin
                  rd_ptr <= ~rd_ptr;
               end
               unique case ({push, pop})
                  2'b10:   occ <= occ + 2'd1;
                  2'b01:   occ <= occ - 2'd1;
                  default: ;
               endcase
               if (sink_hs) begin
                  out_count <= out_count + LEN_W'(1);
               end
`ifdef FRAME_CTRL_TIMEOUT_EN
               if (push || sink_hs) begin
                  wd_cnt <= '0;
               end else begin
                  wd_cnt <= wd_cnt + TIMEOUT_W'(1);
               end
`endif
               if (complete || wd_expired) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
               if (wd_expired) begin
                  // Abandon whatever is still buffered; the frame is dead.
                  occ    <= 2'd0;
                  rd_ptr <= 1'b0;
                  wr_ptr <= 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
                  timeout <= 1'b1;
`endif
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_ctrl.sv
// tb_frame_ctrl: scoreboard bench for frame_ctrl.
// Single stimulus/monitor process: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.

module tb_frame_ctrl;

   localparam int DW = 64;
   localparam int LW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] in_len = '0;
   logic [LW-1:0] out_len = '0;
   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] src_data;
   logic          pipe_valid;
   logic          pipe_ready = 1'b0;
   logic [DW-1:0] pipe_data;
   logic          ret_valid;
   logic          ret_ready;
   logic [DW-1:0] ret_data;
   logic          sink_valid;
   logic          sink_ready = 1'b0;
   logic [DW-1:0] sink_data;
   logic          busy;
   logic          done;
   logic [LW-1:0] in_count;
   logic [LW-1:0] out_count;
   logic          timeout;

   always #5 clk = ~clk;

   frame_ctrl #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_len(in_len), .out_len(out_len),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_data(pipe_data),
      .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data),
      .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data),
      .busy(busy), .done(done), .in_count(in_count), .out_count(out_count),
      .timeout(timeout)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;

   // Stimulus sources.
   logic src_en = 1'b0;
   logic ret_en = 1'b0;
   int   src_idx = 0;
   int   ret_idx = 0;
   int   ret_limit = 0;
   int   pipe_mode = 0;     // 0: always ready, 1: 1,0,0 repeating, 2: stalled
   logic src_hs_f = 1'b0;
   logic ret_hs_f = 1'b0;

   assign src_valid = src_en;
   assign src_data  = 64'hA000_0000_0000_0000 | 64'(src_idx);
   assign ret_valid = ret_en && (ret_idx < ret_limit);
   assign ret_data  = 64'hB000_0000_0000_0000 | 64'(ret_idx);

   // Reference model of the frame.
   int e_in = 0, e_out = 0, m_in = 0, m_out = 0, m_occ = 0;
   int n_pipe = 0, n_sink = 0, done_n = 0, occ2_seen = 0;
   int start_cyc = 0, done_cyc = 0, last_sink_cyc = 0;
   logic [DW-1:0] pipe_q[$];
   logic [DW-1:0] sink_q[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic mon();
      if (rst_n) begin
         if (start) start_cyc = cyc;
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
         if (busy) begin
            check_eq("src_ready", 64'(src_ready), 64'((m_in != e_in) && (m_occ < 2)));
            check_eq("pipe_valid", 64'(pipe_valid), 64'(m_occ != 0));
            check_eq("ret_ready", 64'(ret_ready), 64'(sink_ready && (m_out != e_out)));
            check_eq("sink_valid", 64'(sink_valid), 64'(ret_valid && (m_out != e_out)));
            check_eq("in_count", 64'(in_count), 64'(m_in));
            check_eq("out_count", 64'(out_count), 64'(m_out));
            if (m_occ == 2) occ2_seen++;
         end else begin
            check_eq("idle_handshake_sigs", 64'({src_ready, ret_ready, sink_valid, pipe_valid}), 64'd0);
         end
         if (pipe_valid && pipe_ready) begin
            if (pipe_q.size() == 0) check_eq("pipe_unexpected", 64'd1, 64'd0);
            else check_eq("pipe_data", pipe_data, pipe_q.pop_front());
            n_pipe++;
            m_occ--;
         end
         if (src_valid && src_ready) begin
            pipe_q.push_back(src_data);
            m_in++;
            m_occ++;
            src_hs_f = 1'b1;
         end
         if (ret_valid && ret_ready) begin
            sink_q.push_back(ret_data);
            ret_hs_f = 1'b1;
         end
         if (sink_valid && sink_ready) begin
            if (sink_q.size() == 0) check_eq("sink_unexpected", 64'd1, 64'd0);
            else check_eq("sink_data", sink_data, sink_q.pop_front());
            n_sink++;
            m_out++;
            last_sink_cyc = cyc;
         end
      end
   endtask

   // One clock: sample mid-cycle, then advance sources just after the edge.
   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
      cyc++;
      if (src_hs_f) src_idx++;
      if (ret_hs_f) ret_idx++;
      src_hs_f = 1'b0;
      ret_hs_f = 1'b0;
      case (pipe_mode)
         0:       pipe_ready = 1'b1;
         1:       pipe_ready = (cyc % 3 == 0);
         default: pipe_ready = 1'b0;
      endcase
   endtask

   task automatic go(input int li, input int lo);
      e_in = li; e_out = lo; m_in = 0; m_out = 0; m_occ = 0;
      n_pipe = 0; n_sink = 0; done_n = 0;
      pipe_q.delete();
      sink_q.delete();
      src_idx = 0;
      ret_idx = 0;
      start = 1'b1;
      in_len = 32'(li);
      out_len = 32'(lo);
      tick();
      start = 1'b0;
      in_len = '1;
      out_len = '1;
      check_eq("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_n == 0; i++) tick();
      check_eq("done_seen", 64'(done_n != 0), 64'd1);
      tick();
      tick();
      check_eq("done_one_cycle", 64'(done_n), 64'd1);
      check_eq("busy_after_done", 64'(busy), 64'd0);
   endtask

   initial begin
      // Reset state, with every input trying to provoke a handshake.
      src_en = 1'b1; ret_en = 1'b1; ret_limit = 100; sink_ready = 1'b1;
      repeat (3) tick();
      check_eq("rst_ready_valid", 64'({src_ready, ret_ready, sink_valid, pipe_valid}), 64'd0);
      check_eq("rst_flags", 64'({busy, done, timeout}), 64'd0);
      check_eq("rst_in_count", 64'(in_count), 64'd0);
      check_eq("rst_out_count", 64'(out_count), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic frame, everything ready.
      pipe_mode = 0;
      go(4, 2);
      wait_done(50);
      check_eq("t1_in_count", 64'(in_count), 64'd4);
      check_eq("t1_out_count", 64'(out_count), 64'd2);
      check_eq("t1_pipe_beats", 64'(n_pipe), 64'd4);
      check_eq("t1_sink_beats", 64'(n_sink), 64'd2);

      // Throttled pipeline; a start mid-frame must be ignored.
      pipe_mode = 1; ret_en = 1'b0; occ2_seen = 0;
      go(8, 0);
      tick(); tick(); tick();
      start = 1'b1; in_len = 32'd2; out_len = 32'd5;
      tick();
      start = 1'b0;
      wait_done(100);
      check_eq("t2_in_count", 64'(in_count), 64'd8);
      check_eq("t2_pipe_beats", 64'(n_pipe), 64'd8);
      check_eq("t2_src_taken", 64'(src_idx), 64'd8);
      check_eq("t2_skid_full_seen", 64'(occ2_seen != 0), 64'd1);
      check_eq("t2_pipe_q_empty", 64'(pipe_q.size()), 64'd0);

      // Pipeline returns more beats than the frame wants.
      pipe_mode = 0; src_en = 1'b0; ret_en = 1'b1; ret_limit = 5;
      go(0, 3);
      wait_done(50);
      check_eq("t3_sink_beats", 64'(n_sink), 64'd3);
      check_eq("t3_out_count", 64'(out_count), 64'd3);
      check_eq("t3_done_timing", 64'(done_cyc - last_sink_cyc), 64'd2);
      tick(); tick(); tick();
      check_eq("t3_excess_held", 64'(ret_idx), 64'd3);

      // Zero-length frame.
      src_en = 1'b1; ret_limit = 100;
      go(0, 0);
      wait_done(10);
      check_eq("t4_done_latency", 64'(done_cyc - start_cyc), 64'd2);
      check_eq("t4_no_handshakes", 64'(n_pipe + n_sink + m_in), 64'd0);

      // Reset with two beats parked in the skid.
      pipe_mode = 2; ret_en = 1'b0;
      go(8, 0);
      for (int i = 0; i < 20 && m_occ != 2; i++) tick();
      check_eq("t5_skid_filled", 64'(m_occ), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_ready_valid", 64'({src_ready, ret_ready, sink_valid, pipe_valid}), 64'd0);
      check_eq("t5_rst_flags", 64'({busy, done, timeout}), 64'd0);
      check_eq("t5_rst_in_count", 64'(in_count), 64'd0);
      pipe_q.delete();
      m_occ = 0;
      src_hs_f = 1'b0;
      ret_hs_f = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      pipe_mode = 0; ret_en = 1'b1; ret_limit = 100;
      tick();
      go(3, 2);
      wait_done(50);
      check_eq("t5_clean_in_count", 64'(in_count), 64'd3);
      check_eq("t5_clean_out_count", 64'(out_count), 64'd2);
      check_eq("t5_clean_pipe_beats", 64'(n_pipe), 64'd3);

`ifdef FRAME_CTRL_TIMEOUT_EN
      // Stalled writer trips the watchdog.
      src_en = 1'b0; sink_ready = 1'b0;
      go(0, 1);
      wait_done(40);
      check_eq("t6_timeout_set", 64'(timeout), 64'd1);
      tick();
      check_eq("t6_timeout_sticky", 64'(timeout), 64'd1);
      sink_ready = 1'b1;
      go(0, 0);
      check_eq("t6_timeout_cleared", 64'(timeout), 64'd0);
      wait_done(10);
`else
      check_eq("timeout_tied_low", 64'(timeout), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/frame_ctrl.md
# frame_ctrl

Per-frame flow controller between the DMA read/write engines and the `pipeWrap` stream stage. Gates a fixed number of 64-bit beats from the DMA read stream into the pipeline, and passes a fixed number of result beats from the pipeline to the DMA write stream. Signals completion with a one-cycle `done` pulse. Breaks the forward ready path into the pipeline with a registered 2-entry skid buffer.

## Interface
- `DATA_W`, 64, beat width on all streams
- `LEN_W`, 32, width of the length registers and beat counters
- `TIMEOUT_W`, 24, watchdog counter width (used only with the macro)
- `clk` in 1: single clock for all logic
- `rst_n` in 1: reset, asynchronous active-low
- `start` in 1: one-cycle pulse that begins a frame; ignored unless in IDLE
- `in_len` in LEN_W: number of beats to feed into the pipeline; sampled on `start`
- `out_len` in LEN_W: number of result beats expected back; sampled on `start`
- `src_valid` in 1; `src_ready` out 1; `src_data` in DATA_W: stream from the DMA reader
- `pipe_valid` out 1; `pipe_ready` in 1; `pipe_data` out DATA_W: stream to the `pipeWrap` input
- `ret_valid` in 1; `ret_ready` out 1; `ret_data` in DATA_W: stream from the `pipeWrap` output
- `sink_valid` out 1; `sink_ready` in 1; `sink_data` out DATA_W: stream to the DMA writer
- `busy` out 1: high in RUN
- `done` out 1: one-cycle completion pulse
- `in_count`, `out_count` out LEN_W: beats accepted and beats delivered in the current or last frame
- `timeout` out 1: sticky watchdog flag (macro only; tied to 0 otherwise)

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - On `start`: latch `in_len` and `out_len`, clear both counters, clear `timeout`, go to RUN.
  - All other inputs are ignored.
- RUN, feed side
  - `src_ready` = (`in_count` != latched in_len) && (skid occupancy < 2). Occupancy is registered, so there is no combinational path from `pipe_ready` to `src_ready`.
  - Each src handshake writes the skid FIFO and increments `in_count`.
  - `pipe_valid` = skid not empty; `pipe_data` = skid head.
  - Simultaneous push and pop leave occupancy unchanged and preserve order.
- RUN, return side (combinational pass-through, gated)
  - Gate g = (`out_count` != latched out_len).
  - `sink_valid` = `ret_valid` & g; `ret_ready` = `sink_ready` & g; `sink_data` = `ret_data`.
  - Each sink handshake increments `out_count`.
- RUN → DONE when all three hold: `in_count` == in_len, skid empty, `out_count` == out_len. Evaluated on registered values.
- DONE lasts one cycle with `done`=1, then returns to IDLE.
- Zero lengths: `in_len`=0 and `out_len`=0 gives RUN for 1 cycle, then DONE.
- Excess pipeline output after `out_count` reaches out_len is held off (`ret_ready`=0). It is never dropped.
- Outside RUN: `src_ready`, `ret_ready`, `sink_valid`, `busy` are 0. `pipe_valid` is 0 because the skid is always empty outside RUN.
- Counters wrap modulo 2^LEN_W; lengths ≥ 2^LEN_W are unsupported.

## Timing
- Reset values:
  - state IDLE, skid empty
  - all valid/ready outputs 0
  - `done`, `busy`, `timeout` 0
  - counters 0, latched lengths 0
- `start` at cycle N: `busy`=1 and `src_ready` may be 1 at N+1.
- Feed latency: a src beat accepted at cycle N is presented on `pipe_valid`/`pipe_data` at N+1.
- Return path has zero latency.
- `done` is asserted the cycle after the completion condition becomes true.
- Asserting `rst_n` low mid-frame: the frame is aborted, skid contents are discarded, and all outputs return to reset values asynchronously.
- `start` while in RUN or DONE is ignored; no state change.

## Configuration
- `FRAME_CTRL_TIMEOUT_EN` defined:
  - A TIMEOUT_W-bit counter runs in RUN. It clears on any src or sink handshake and increments otherwise.
  - At all-ones it forces DONE: sets `timeout` (sticky until the next accepted `start`), pulses `done`, and discards the skid.
- Undefined: no counter is built, `timeout` is tied 0, and a stalled frame stays in RUN until reset.

## Test plan
- `in_len`=4, `out_len`=2, all readies/valids high → 4 beats on pipe in order, each 1 cycle after src accept; 2 beats on sink; `done` pulse; `in_count`=4, `out_count`=2.
- `pipe_ready` toggled 1,0,0,1,…, `src_valid` held high, `in_len`=8 → `src_ready` drops when occupancy=2; no beat lost or duplicated; data order is 0..7.
- `out_len`=3 with the pipe returning 5 beats → sink sees exactly 3; `ret_ready`=0 afterward; `done` only after the 3rd sink handshake.
- `in_len`=0, `out_len`=0, `start` → `done` 2 cycles after `start`; no handshakes occur.
- `rst_n` pulsed low with 2 beats in the skid mid-frame → outputs immediately at reset values; next `start` runs a clean frame with counters from 0.
- With `FRAME_CTRL_TIMEOUT_EN` and TIMEOUT_W=4, `sink_ready` held 0 → after 15 idle cycles `timeout`=1, `done` pulse, back in IDLE; the next `start` clears `timeout`.
